// File: rtl/sram_bridge_pkg.sv
// Shared types and constants for the 32-bit core to 16-bit async SRAM bridge.
package sram_bridge_pkg;

  localparam int unsigned WAIT_CYCLES_DEFAULT = 2;

  localparam int unsigned ADDR_W  = 18;
  localparam int unsigned WADDR_W = 16;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BE_W    = 4;
  localparam int unsigned SRAM_AW = 17;
  localparam int unsigned SRAM_DW = 16;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Request as captured on acceptance; waddr drops the ignored byte-offset bits
  typedef struct packed {
    logic               we;
    logic [WADDR_W-1:0] waddr;
    logic [DATA_W-1:0]  wdata;
    logic [BE_W-1:0]    be;
  } req_t;

endpackage

// File: rtl/sram_bridge_if.sv
// Core-side request/response bus of the SRAM bridge.
interface sram_bridge_if;
  import sram_bridge_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata
  );

endinterface

// File: rtl/sram_bridge.sv
// Splits each 32-bit core access into up to two 16-bit async SRAM cycles
// (SETUP then WAIT_CYCLES of STROBE per halfword). All pin controls are registered.
module sram_bridge
  import sram_bridge_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  sram_bridge_if.slave       bus,
  output logic               sram_cs1_n,
  output logic               sram_cs2,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               sram_lb_n,
  output logic               sram_ub_n,
  output logic [SRAM_AW-1:0] sram_a,
  inout  wire  [SRAM_DW-1:0] sram_io
);

  state_e             r_state;
  logic               r_half;
  logic [CNT_W-1:0]   r_cnt;
  req_t               r_req;

  logic               r_cs1_n, r_cs2, r_oe_n, r_we_n, r_lb_n, r_ub_n;
  logic [SRAM_AW-1:0] r_sram_a;
  logic               r_io_oe;
  logic [SRAM_DW-1:0] r_io_dout;
  logic               r_req_ready, r_resp_valid;
  logic [SRAM_DW-1:0] r_rd_lo;
  logic [DATA_W-1:0]  r_rdata;

  state_e             w_state_nxt;
  logic               w_half_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  req_t               w_req_nxt;
  logic               w_last_strobe;
  logic               w_active, w_strobe;
  logic               w_cs1_n_nxt, w_cs2_nxt, w_oe_n_nxt, w_we_n_nxt, w_lb_n_nxt, w_ub_n_nxt;
  logic [SRAM_AW-1:0] w_sram_a_nxt;
  logic               w_io_oe_nxt;
  logic [SRAM_DW-1:0] w_io_dout_nxt;
  logic               w_req_ready_nxt, w_resp_valid_nxt;
  logic               w_unused_addr_lsb;

  assign w_unused_addr_lsb = ^bus.req_addr[1:0];

  // Next state, request capture, and next values for the registered pins
  always_comb begin
    w_state_nxt   = r_state;
    w_half_nxt    = r_half;
    w_cnt_nxt     = r_cnt;
    w_req_nxt     = r_req;
    w_last_strobe = 1'b0;
    w_lb_n_nxt    = 1'b1;
    w_ub_n_nxt    = 1'b1;

    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          w_req_nxt = '{we:    bus.req_we,
                        waddr: bus.req_addr[ADDR_W-1:2],
                        wdata: bus.req_wdata,
                        be:    bus.req_be};
          if (!bus.req_we || (bus.req_be[1:0] != 2'b00)) begin
            w_state_nxt = SETUP;
            w_half_nxt  = 1'b0;
          end else if (bus.req_be[3:2] != 2'b00) begin
            w_state_nxt = SETUP;
            w_half_nxt  = 1'b1;
          end else begin
            w_state_nxt = DONE;
          end
        end
      end
      SETUP: begin
        w_state_nxt = STROBE;
        w_cnt_nxt   = CNT_W'(WAIT_CYCLES - 1);
      end
      STROBE: begin
        if (r_cnt == '0) begin
          w_last_strobe = 1'b1;
          if (!r_half && (!r_req.we || (r_req.be[3:2] != 2'b00))) begin
            w_state_nxt = SETUP;
            w_half_nxt  = 1'b1;
          end else begin
            w_state_nxt = DONE;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_half_nxt  = 1'b0;
      end
      default: w_state_nxt = IDLE;
    endcase

    w_active     = (w_state_nxt == SETUP) || (w_state_nxt == STROBE);
    w_strobe     = (w_state_nxt == STROBE);
    w_cs1_n_nxt  = ~w_active;
    w_cs2_nxt    = w_active;
    w_sram_a_nxt = w_active ? {w_req_nxt.waddr, w_half_nxt} : r_sram_a;
    w_oe_n_nxt   = ~(w_strobe && !w_req_nxt.we);
    w_we_n_nxt   = ~(w_strobe && w_req_nxt.we);
    if (w_active) begin
      if (w_req_nxt.we) begin
        w_lb_n_nxt = ~(w_half_nxt ? w_req_nxt.be[2] : w_req_nxt.be[0]);
        w_ub_n_nxt = ~(w_half_nxt ? w_req_nxt.be[3] : w_req_nxt.be[1]);
      end else begin
        w_lb_n_nxt = 1'b0;
        w_ub_n_nxt = 1'b0;
      end
    end
    w_io_oe_nxt      = w_active && w_req_nxt.we;
    w_io_dout_nxt    = w_half_nxt ? w_req_nxt.wdata[DATA_W-1:SRAM_DW] : w_req_nxt.wdata[SRAM_DW-1:0];
    w_resp_valid_nxt = (w_state_nxt == DONE);
    w_req_ready_nxt  = (w_state_nxt == IDLE);
  end

  // FSM state, halfword select, wait counter and captured request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_half  <= 1'b0;
      r_cnt   <= '0;
      r_req   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_half  <= w_half_nxt;
      r_cnt   <= w_cnt_nxt;
      r_req   <= w_req_nxt;
    end
  end

  // Registered SRAM pins and core handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cs1_n      <= 1'b1;
      r_cs2        <= 1'b0;
      r_oe_n       <= 1'b1;
      r_we_n       <= 1'b1;
      r_lb_n       <= 1'b1;
      r_ub_n       <= 1'b1;
      r_sram_a     <= '0;
      r_io_oe      <= 1'b0;
      r_io_dout    <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
    end else begin
      r_cs1_n      <= w_cs1_n_nxt;
      r_cs2        <= w_cs2_nxt;
      r_oe_n       <= w_oe_n_nxt;
      r_we_n       <= w_we_n_nxt;
      r_lb_n       <= w_lb_n_nxt;
      r_ub_n       <= w_ub_n_nxt;
      r_sram_a     <= w_sram_a_nxt;
      r_io_oe      <= w_io_oe_nxt;
      r_io_dout    <= w_io_dout_nxt;
      r_req_ready  <= w_req_ready_nxt;
      r_resp_valid <= w_resp_valid_nxt;
    end
  end

  // Read capture; the low half is staged so resp_rdata only changes when a read completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_lo <= '0;
      r_rdata <= '0;
    end else if (w_last_strobe && !r_req.we) begin
      if (!r_half) begin
        r_rd_lo <= sram_io;
      end else begin
        r_rdata <= {sram_io, r_rd_lo};
      end
    end
  end

  assign sram_io        = r_io_oe ? r_io_dout : {SRAM_DW{1'bz}};
  assign sram_cs1_n     = r_cs1_n;
  assign sram_cs2       = r_cs2;
  assign sram_oe_n      = r_oe_n;
  assign sram_we_n      = r_we_n;
  assign sram_lb_n      = r_lb_n;
  assign sram_ub_n      = r_ub_n;
  assign sram_a         = r_sram_a;
  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_rdata;

endmodule
